// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and frame-aligns three push buttons into one-cycle move requests.
// Latency: raw edge -> debounced edge 2+DB_CYCLES cycles, +1 to pending, output the cycle after the next frame.
// Backpressure: none; requests that arrive between frames collapse into a single pending request.
//
// Ports: vclk (clock), rst (async active-high reset), frame (one-cycle frame pulse),
//        btn_left/btn_right/btn_down (raw asynchronous buttons), LEFT/RIGHT/DOWN (registered request pulses).
// Build option: define KEY_AUTOREPEAT_EN to generate repeat requests while a button is held;
//               without it each press yields exactly one request and no frame counters exist.

module key_conditioner_chan #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 20,
    parameter int DELAY     = 12,
    parameter int RATE      = 4
) (
    input  logic vclk,
    input  logic rst,
    input  logic frame_i,
    input  logic btn_i,
    output logic pend_o
);

    logic [1:0]      sync_q;
    logic            db_q, db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pend_q;

    // Debouncer: count only while the synchronized level disagrees with the debounced one.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                db_d     = ~db_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int MAXV = (DELAY > RATE) ? DELAY : RATE;
    localparam int CW   = $clog2(MAXV + 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;
    state_t        state_q;
    logic [CW-1:0] fcnt_q;

    // Pending clears on every frame (emitted or cancelled by the conflict rule);
    // a set in the same cycle overrides the clear because it is assigned later.
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            if (frame_i) pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (db_q) begin
                        state_q <= S_DELAY;
                        fcnt_q  <= CW'(DELAY);
                        pend_q  <= 1'b1;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (!db_q) begin
                        state_q <= S_IDLE;
                        fcnt_q  <= '0;
                    end else if (frame_i) begin
                        if (fcnt_q == CW'(1)) begin
                            state_q <= S_REPEAT;
                            fcnt_q  <= CW'(RATE);
                            pend_q  <= 1'b1;
                        end else begin
                            fcnt_q <= fcnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    typedef enum logic {S_IDLE, S_HELD} state_t;
    state_t state_q;

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
        end else begin
            if (frame_i) pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (db_q) begin
                        state_q <= S_HELD;
                        pend_q  <= 1'b1;
                    end
                end
                S_HELD: begin
                    if (!db_q) state_q <= S_IDLE;
                end
            endcase
        end
    end
`endif

    assign pend_o = pend_q;

endmodule

module key_conditioner #(
    parameter int DB_CYCLES    = 500000,
    parameter int DB_W         = 20,
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 4,
    parameter int DOWN_RATE    = 2
) (
    input  logic vclk,
    input  logic rst,
    input  logic frame,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    output logic LEFT,
    output logic RIGHT,
    output logic DOWN
);

    logic pend_left, pend_right, pend_down;
    logic left_q, left_d, right_q, right_d, down_q, down_d;

    key_conditioner_chan #(
        .DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)
    ) u_left (
        .vclk(vclk), .rst(rst), .frame_i(frame), .btn_i(btn_left), .pend_o(pend_left)
    );

    key_conditioner_chan #(
        .DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)
    ) u_right (
        .vclk(vclk), .rst(rst), .frame_i(frame), .btn_i(btn_right), .pend_o(pend_right)
    );

    key_conditioner_chan #(
        .DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .DELAY(REPEAT_DELAY), .RATE(DOWN_RATE)
    ) u_down (
        .vclk(vclk), .rst(rst), .frame_i(frame), .btn_i(btn_down), .pend_o(pend_down)
    );

    // Simultaneous left and right requests cancel each other; both pendings still clear.
    always_comb begin
        left_d  = frame & pend_left  & ~pend_right;
        right_d = frame & pend_right & ~pend_left;
        down_d  = frame & pend_down;
    end

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            down_q  <= down_d;
        end
    end

    assign LEFT  = left_q;
    assign RIGHT = right_q;
    assign DOWN  = down_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner: directed stimulus with a scoreboard of expected pulse (channel, cycle) pairs.
// Frames occur at every 20th clock edge; expected pulse cycles are derived from press/release cycles.
// Runs with or without KEY_AUTOREPEAT_EN; repeat expectations follow the same macro.

module tb_key_conditioner;

    logic vclk      = 1'b0;
    logic rst       = 1'b1;
    logic frame     = 1'b0;
    logic btn_left  = 1'b0;
    logic btn_right = 1'b0;
    logic btn_down  = 1'b0;
    logic LEFT, RIGHT, DOWN;

    int cyc      = 0;   // number of rising edges seen so far
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_q[$];       // expected pulses encoded as chan*100000 + cycle
    int n_pulse [1:3] = '{0, 0, 0};
    int base    [1:3] = '{0, 0, 0};

    key_conditioner #(
        .DB_CYCLES(4), .DB_W(3), .REPEAT_DELAY(3), .REPEAT_RATE(2), .DOWN_RATE(1)
    ) dut (
        .vclk(vclk), .rst(rst), .frame(frame),
        .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .LEFT(LEFT), .RIGHT(RIGHT), .DOWN(DOWN)
    );

    always #5 vclk = ~vclk;

    always @(posedge vclk) cyc <= cyc + 1;

    // Frame is sampled high at every edge whose number is a multiple of 20.
    initial begin
        forever begin
            @(negedge vclk);
            frame = ((cyc + 1) % 20 == 0);
        end
    end

    task automatic check(input string tag, input int obs, input int want);
        n_checks++;
        assert (obs === want) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic observe(input int chan);
        int want;
        want = -1;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        check("pulse", chan * 100000 + cyc, want);
        n_pulse[chan]++;
    endtask

    always @(negedge vclk) begin
        if (LEFT === 1'b1)  observe(1);
        if (RIGHT === 1'b1) observe(2);
        if (DOWN === 1'b1)  observe(3);
    end

    function automatic int next_frame(input int c);
        return ((c + 19) / 20) * 20;
    endfunction

    task automatic push(input int chan, input int c);
        exp_q.push_back(chan * 100000 + c);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge vclk);
        #1;
    endtask

    task automatic begin_scenario();
        for (int i = 1; i <= 3; i++) base[i] = n_pulse[i];
    endtask

    task automatic end_scenario(input string tag, input int el, input int er, input int ed);
        check({tag, "_left_count"},  n_pulse[1] - base[1], el);
        check({tag, "_right_count"}, n_pulse[2] - base[2], er);
        check({tag, "_down_count"},  n_pulse[3] - base[3], ed);
        check({tag, "_missing"},     exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic align_frame();
        while (cyc % 20 != 0) wait_cyc(1);
    endtask

    initial begin
        int c;
        int f1;
        int nd;

        // Reset held 5 cycles.
        wait_cyc(5);
        check("reset_outputs", int'({LEFT, RIGHT, DOWN}), 0);
        rst = 1'b0;

        // Idle 200 cycles with all buttons low.
        begin_scenario();
        wait_cyc(200);
        end_scenario("idle", 0, 0, 0);

        // Bouncing left press, then a steady hold of 40 cycles.
        begin_scenario();
        c = 0;
        for (int i = 0; i < 5; i++) begin
            btn_left = (i % 2 == 0);
            if (i % 2 == 0) c = cyc;
            wait_cyc(2);
        end
        push(1, next_frame(c + 8));
        wait_cyc(38);
        btn_left = 1'b0;
        wait_cyc(60);
        end_scenario("bounce", 1, 0, 0);

        // Down held 200 cycles.
        begin_scenario();
        c = cyc;
        btn_down = 1'b1;
        f1 = next_frame(c + 8);
        push(3, f1);
        nd = 1;
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 3; f1 + 20 * (k - 1) <= c + 206; k++) begin
            push(3, f1 + 20 * k);
            nd++;
        end
`endif
        wait_cyc(200);
        btn_down = 1'b0;
        wait_cyc(60);
        end_scenario("down_hold", 0, 0, nd);

        // Left and right together cancel.
        begin_scenario();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        wait_cyc(30);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        wait_cyc(60);
        end_scenario("conflict", 0, 0, 0);

        // Left, right and down together: only DOWN.
        begin_scenario();
        c = cyc;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        btn_down  = 1'b1;
        push(3, next_frame(c + 8));
        wait_cyc(30);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_down  = 1'b0;
        wait_cyc(60);
        end_scenario("conflict_down", 0, 0, 1);

        // Right pressed and released inside one frame interval.
        align_frame();
        begin_scenario();
        c = cyc;
        btn_right = 1'b1;
        push(2, c + 20);
        wait_cyc(6);
        btn_right = 1'b0;
        wait_cyc(60);
        end_scenario("short_right", 0, 1, 0);

        // Reset in the middle of a left hold; the hold counts as a new press afterwards.
        align_frame();
        begin_scenario();
        c = cyc;
        btn_left = 1'b1;
        wait_cyc(10);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            check("in_reset_outputs", int'({LEFT, RIGHT, DOWN}), 0);
        end
        rst = 1'b0;
        push(1, next_frame(cyc + 8));
        wait_cyc(37);
        btn_left = 1'b0;
        wait_cyc(60);
        end_scenario("reset_hold", 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
